// File: rtl/downcounter_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : downcounter_8bit
//  Description : Loadable down-counting interval timer. It counts from a loaded
//                value to zero on enabled cycles and flags the terminal count
//                with a one-cycle tc pulse. An optional auto-reload mode turns
//                it into a periodic tick source.
//  Revision    : 1.0  initial release
// ============================================================================
module downcounter_8bit #(
    parameter int WIDTH       = 8,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    output logic [WIDTH-1:0] Qout,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] C_ZERO        = '0;
    localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);
    localparam bit               C_AUTO_RELOAD = (AUTO_RELOAD != 0);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // ------------------------------------------------------------------------
    // Count decode helpers
    // ------------------------------------------------------------------------
    logic             w_count_zero;
    logic             w_count_one;
    logic             w_reload_zero;
    logic [WIDTH-1:0] w_count_dec;

    assign w_count_zero  = (count_q == C_ZERO);
    assign w_count_one   = (count_q == C_ONE);
    assign w_reload_zero = (reload_q == C_ZERO);
    // Only consumed when the count is above one, so it can never wrap.
    assign w_count_dec   = count_q - C_ONE;

    // Next-state, next-count and terminal-count pulse; priority is
    // load > stop > start > count (reset handled in the register block).
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = din;
            reload_d = din;
            state_d  = ST_IDLE;
        end else if (stop) begin
            // Abort a running count and freeze the value; in IDLE/DONE stop
            // simply masks start for this cycle.
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (w_count_zero) begin
                            // Nothing to count: terminate immediately.
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    // start is ignored while running; en qualifies each step.
                    if (en) begin
                        if (w_count_zero) begin
                            // Only reachable in auto-reload mode, one enabled
                            // cycle after the terminal count.
                            if (C_AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else if (w_count_one) begin
                            count_d = C_ZERO;
                            tc_d    = 1'b1;
                            if (!C_AUTO_RELOAD) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = w_count_dec;
                        end
                    end
                end

                ST_DONE: begin
                    count_d = C_ZERO;
                    if (start) begin
                        if (w_reload_zero) begin
                            // Zero-length interval: re-flag terminal count.
                            tc_d = 1'b1;
                        end else begin
                            count_d = reload_q;
                            state_d = ST_RUN;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    count_d = C_ZERO;
                end
            endcase
        end

        // Status flags are registered copies of the next state.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= C_ZERO;
            reload_q <= C_ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Qout = count_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_downcounter_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_downcounter_8bit
//  Description : Self-checking bench for downcounter_8bit. Two instances are
//                driven in lock-step, one without and one with auto-reload;
//                each vector names which instance it checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_downcounter_8bit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;

    logic [7:0] q0, q1;
    logic       tc0, tc1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    downcounter_8bit #(.WIDTH(8), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .din(din), .start(start),
        .stop(stop), .en(en), .Qout(q0), .tc(tc0), .busy(busy0), .done(done0)
    );

    downcounter_8bit #(.WIDTH(8), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .din(din), .start(start),
        .stop(stop), .en(en), .Qout(q1), .tc(tc1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] d;
        logic       st;
        logic       sp;
        logic       e;
        logic       sel;
        logic [7:0] q;
        logic       tc;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        int         id;
        logic       sel;
        logic [7:0] q;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic ld, input logic [7:0] d,
                                input logic st, input logic sp, input logic e,
                                input logic sel, input logic [7:0] q, input logic t,
                                input logic b, input logic dn);
        vec_t v;
        v.rst = rst; v.ld = ld; v.d = d; v.st = st; v.sp = sp; v.e = e;
        v.sel = sel; v.q = q; v.tc = t; v.busy = b; v.done = dn;
        return v;
    endfunction

    task automatic chk(input string what, input int id, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL vec%0d %s: got %0h expected %0h", id, what, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input int id);
        exp_t e, x;
        @(negedge clk);
        reset = v.rst; load = v.ld; din = v.d;
        start = v.st;  stop = v.sp; en = v.e;
        e.id = id; e.sel = v.sel; e.q = v.q; e.tc = v.tc; e.busy = v.busy; e.done = v.done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (x.sel) begin
            chk("Qout", x.id, q1, x.q);
            chk("tc",   x.id, {7'd0, tc1},   {7'd0, x.tc});
            chk("busy", x.id, {7'd0, busy1}, {7'd0, x.busy});
            chk("done", x.id, {7'd0, done1}, {7'd0, x.done});
            chk("busy&done", x.id, {7'd0, busy1 & done1}, 8'd0);
        end else begin
            chk("Qout", x.id, q0, x.q);
            chk("tc",   x.id, {7'd0, tc0},   {7'd0, x.tc});
            chk("busy", x.id, {7'd0, busy0}, {7'd0, x.busy});
            chk("done", x.id, {7'd0, done0}, {7'd0, x.done});
            chk("busy&done", x.id, {7'd0, busy0 & done0}, 8'd0);
        end
    endtask

    initial begin
        int         id;
        logic [7:0] qexp;
        logic       e_bit;
        int         iter;

        //              rst ld din   st sp en sel  q     tc b  d
        // Reset state
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        // Count 5 down to zero, then sit in DONE without underflow
        tbl.push_back(mk(0, 1, 8'h05, 0, 0, 0, 0, 8'h05, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h05, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h04, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        // Restart from DONE reloads 5; stop+start in RUN goes IDLE
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h05, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h04, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 8'h04, 0, 0, 0));
        // Load 6, gated enable, stop at 3, resume
        tbl.push_back(mk(0, 1, 8'h06, 0, 0, 0, 0, 8'h06, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h06, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h05, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h05, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h04, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h04, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h03, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h03, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        // Load 0 then start: immediate DONE with tc; restart with reload 0
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 1));
        // load and start together: load wins
        tbl.push_back(mk(0, 1, 8'h09, 1, 0, 0, 0, 8'h09, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h09, 0, 0, 0));
        // Reset mid-count aborts with no tc
        tbl.push_back(mk(0, 1, 8'h37, 0, 0, 0, 0, 8'h37, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h37, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h36, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h35, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h34, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h33, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h32, 0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0));
        // Auto-reload instance: 3,2,1,0,3,2,1,0,3 with busy held
        tbl.push_back(mk(0, 1, 8'h03, 0, 0, 0, 1, 8'h03, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h03, 0, 1, 0));
        // Auto-reload with reload==1: tc every other cycle; en=0 holds at 0
        tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 1, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h01, 0, 1, 0));

        id = 0;
        foreach (tbl[i]) begin
            apply(tbl[i], id);
            id++;
        end

        // Long count from 200 with a random enable pattern on the one-shot
        // instance: value tracks enabled cycles, single tc, then DONE at 0.
        apply(mk(0, 1, 8'd200, 0, 0, 0, 0, 8'd200, 0, 0, 0), id); id++;
        apply(mk(0, 0, 8'd0,   1, 0, 0, 0, 8'd200, 0, 1, 0), id); id++;
        qexp = 8'd200;
        iter = 0;
        while (qexp != 8'd0 && iter < 1000) begin
            e_bit = 1'($urandom_range(0, 1));
            if (e_bit) qexp = qexp - 8'd1;
            apply(mk(0, 0, 8'd0, 0, 0, e_bit, 0, qexp,
                     e_bit && (qexp == 8'd0), qexp != 8'd0, qexp == 8'd0), id);
            id++;
            iter++;
        end
        checks++;
        if (qexp != 8'd0) begin
            errors++;
            $display("FAIL countdown budget: remaining %0d expected 0", qexp);
        end
        // Enable held in DONE must not underflow.
        apply(mk(0, 0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, 1), id); id++;
        apply(mk(0, 0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, 1), id); id++;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
